// File: rtl/cpu_sysid_pkg.sv
// Shared definitions for the sysid checker: FSM encoding, default expected
// sysid words and the saturating error-count helper.
package cpu_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ID   = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_RD_TS   = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_CHECK   = 3'd5
  } state_t;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd2;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1498981549;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/cpu_sysid_checker_timer.sv
// Loadable down-counter that stops at zero; used for both the read-latency
// wait and the auto-recheck interval.
module cpu_sysid_checker_timer #(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= RESET_VALUE;
    end else if (load) begin
      r_count <= load_value;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/cpu_sysid_checker.sv
// Reads the two sysid words over Avalon-MM, compares them with the expected
// build constants and keeps a sticky valid flag plus a saturating error count.
module cpu_sysid_checker
  import cpu_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned RECHECK_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic        sysid_waitrequest,
  input  logic [31:0] sysid_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        mismatch,
  output logic [7:0]  err_count,
  output logic [2:0]  o_dbg_state
);

  // Avalon handshake: a read is accepted on any edge where sysid_read=1 and
  // sysid_waitrequest=0; address and read are held steady until then.
  localparam logic [1:0]  LAT_LOAD   = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam logic [31:0] RC_LOAD    = 32'(RECHECK_CYCLES);
  localparam logic        RC_ENABLED = (RECHECK_CYCLES != 0);
  localparam logic        NO_LATENCY = (READ_LATENCY == 0);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        r_done;
  logic        r_valid;
  logic        r_mismatch;
  logic [7:0]  r_err_count;

  logic w_accept;
  logic w_cap_id;
  logic w_cap_ts;
  logic w_lat_load;
  logic w_lat_en;
  logic w_lat_zero;
  logic w_rc_load;
  logic w_rc_en;
  logic w_rc_zero;
  logic w_auto;
  logic w_mismatch;

  assign w_accept   = sysid_read && !sysid_waitrequest;
  assign w_lat_en   = (r_state == ST_WAIT_ID) || (r_state == ST_WAIT_TS);
  assign w_rc_load  = (r_state == ST_CHECK);
  assign w_rc_en    = (r_state == ST_IDLE);
  assign w_auto     = RC_ENABLED && w_rc_zero;
  assign w_mismatch = (r_id_value != EXPECTED_ID) || (r_ts_value != EXPECTED_TS);

  // Loaded with L-1 so the zero flag lines up with the Lth edge after acceptance.
  cpu_sysid_checker_timer #(
    .WIDTH       (2),
    .RESET_VALUE (2'd0)
  ) u_lat_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (w_lat_load),
    .enable     (w_lat_en),
    .load_value (LAT_LOAD),
    .zero       (w_lat_zero)
  );

  cpu_sysid_checker_timer #(
    .WIDTH       (32),
    .RESET_VALUE (RC_LOAD)
  ) u_rc_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (w_rc_load),
    .enable     (w_rc_en),
    .load_value (RC_LOAD),
    .zero       (w_rc_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cap_id   = 1'b0;
    w_cap_ts   = 1'b0;
    w_lat_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start || w_auto) begin
          w_next = ST_RD_ID;
        end
      end
      ST_RD_ID: begin
        if (w_accept) begin
          if (NO_LATENCY) begin
            w_cap_id = 1'b1;
            w_next   = ST_RD_TS;
          end else begin
            w_lat_load = 1'b1;
            w_next     = ST_WAIT_ID;
          end
        end
      end
      ST_WAIT_ID: begin
        if (w_lat_zero) begin
          w_cap_id = 1'b1;
          w_next   = ST_RD_TS;
        end
      end
      ST_RD_TS: begin
        if (w_accept) begin
          if (NO_LATENCY) begin
            w_cap_ts = 1'b1;
            w_next   = ST_CHECK;
          end else begin
            w_lat_load = 1'b1;
            w_next     = ST_WAIT_TS;
          end
        end
      end
      ST_WAIT_TS: begin
        if (w_lat_zero) begin
          w_cap_ts = 1'b1;
          w_next   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_id_value  <= '0;
      r_ts_value  <= '0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_mismatch  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_done <= (r_state == ST_CHECK);
      if (w_cap_id) begin
        r_id_value <= sysid_readdata;
      end
      if (w_cap_ts) begin
        r_ts_value <= sysid_readdata;
      end
      if (r_state == ST_CHECK) begin
        r_mismatch <= w_mismatch;
        r_valid    <= 1'b1;
        if (w_mismatch) begin
          r_err_count <= sat_inc8(r_err_count);
        end
      end
    end
  end

  assign sysid_read    = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
  assign sysid_address = (r_state == ST_RD_TS) || (r_state == ST_WAIT_TS);
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign valid         = r_valid;
  assign mismatch      = r_mismatch;
  assign err_count     = r_err_count;
  assign id_value      = r_id_value;
  assign ts_value      = r_ts_value;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cpu_sysid_checker.sv
// Directed bench for cpu_sysid_checker: default build, READ_LATENCY=2 build
// and RECHECK_CYCLES=10 build, each with its own sysid slave model.
module tb_cpu_sysid_checker;
  import cpu_sysid_pkg::*;

  localparam logic [31:0] GOOD_ID = 32'd2;
  localparam logic [31:0] GOOD_TS = 32'd1498981549;
  localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // default instance
  logic        rst0, start0, wait0;
  logic [31:0] s0_id, s0_ts, rd0, id0, ts0;
  logic        addr0, read0, busy0, done0, valid0, mm0;
  logic [7:0]  err0;
  logic [2:0]  dbg0;
  // READ_LATENCY=2 instance
  logic        rst1, start1, wait1;
  logic [31:0] rd1, id1, ts1;
  logic        addr1, read1, busy1, done1, valid1, mm1;
  logic [7:0]  err1;
  logic [2:0]  dbg1;
  logic [1:0]  s1_v, s1_a;
  // RECHECK_CYCLES=10 instance
  logic        rst2, start2, wait2;
  logic [31:0] rd2, id2, ts2;
  logic        addr2, read2, busy2, done2, valid2, mm2;
  logic [7:0]  err2;
  logic [2:0]  dbg2;

  cpu_sysid_checker u_dut0 (
    .clock(clock), .reset_n(rst0), .start(start0),
    .sysid_address(addr0), .sysid_read(read0), .sysid_waitrequest(wait0),
    .sysid_readdata(rd0), .id_value(id0), .ts_value(ts0), .busy(busy0),
    .done(done0), .valid(valid0), .mismatch(mm0), .err_count(err0),
    .o_dbg_state(dbg0)
  );

  cpu_sysid_checker #(.READ_LATENCY(2)) u_dut1 (
    .clock(clock), .reset_n(rst1), .start(start1),
    .sysid_address(addr1), .sysid_read(read1), .sysid_waitrequest(wait1),
    .sysid_readdata(rd1), .id_value(id1), .ts_value(ts1), .busy(busy1),
    .done(done1), .valid(valid1), .mismatch(mm1), .err_count(err1),
    .o_dbg_state(dbg1)
  );

  cpu_sysid_checker #(.RECHECK_CYCLES(10)) u_dut2 (
    .clock(clock), .reset_n(rst2), .start(start2),
    .sysid_address(addr2), .sysid_read(read2), .sysid_waitrequest(wait2),
    .sysid_readdata(rd2), .id_value(id2), .ts_value(ts2), .busy(busy2),
    .done(done2), .valid(valid2), .mismatch(mm2), .err_count(err2),
    .o_dbg_state(dbg2)
  );

  // Zero-latency slaves drive data only while read is asserted.
  assign rd0 = read0 ? (addr0 ? s0_ts : s0_id) : JUNK;
  assign rd2 = read2 ? (addr2 ? GOOD_TS : GOOD_ID) : JUNK;

  // Two-cycle slave: data is present only in the cycle before the 2nd edge after acceptance.
  always @(posedge clock or negedge rst1) begin
    if (!rst1) begin
      s1_v <= 2'b00;
      s1_a <= 2'b00;
    end else begin
      s1_v <= {s1_v[0], read1 & ~wait1};
      s1_a <= {s1_a[0], addr1};
    end
  end
  assign rd1 = s1_v[1] ? (s1_a[1] ? GOOD_TS : GOOD_ID) : JUNK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run0(output int lat);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    lat = 0;
    while (done0 !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic run1(output int lat);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    lat = 0;
    while (done1 !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
  endtask

  logic [2:0] exp_st1 [7];
  logic [6:0] exp_rd1, exp_ad1, exp_dn1;

  initial begin
    int lat;
    int cnt;
    logic seen;

    exp_st1 = '{ST_WAIT_ID, ST_WAIT_ID, ST_RD_TS, ST_WAIT_TS, ST_WAIT_TS, ST_CHECK, ST_IDLE};
    exp_rd1 = 7'b0000100;
    exp_ad1 = 7'b0011100;
    exp_dn1 = 7'b1000000;

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    wait0 = 1'b0; wait1 = 1'b0; wait2 = 1'b0;
    s0_id = GOOD_ID; s0_ts = GOOD_TS;
    step();
    step();

    // reset state
    chk("rst_done",  32'(done0),  32'd0);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_mm",    32'(mm0),    32'd0);
    chk("rst_err",   32'(err0),   32'd0);
    chk("rst_busy",  32'(busy0),  32'd0);
    chk("rst_read",  32'(read0),  32'd0);
    chk("rst_addr",  32'(addr0),  32'd0);
    chk("rst_id",    id0,         32'd0);
    chk("rst_ts",    ts0,         32'd0);
    chk("rst_state", 32'(dbg0),   32'(ST_IDLE));

    rst0 = 1'b1; rst1 = 1'b1;
    step();

    // good check, cycle by cycle
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("a_busy",      32'(busy0), 32'd1);
    chk("a_read_id",   32'(read0), 32'd1);
    chk("a_addr_id",   32'(addr0), 32'd0);
    step();
    chk("a_read_ts",   32'(read0), 32'd1);
    chk("a_addr_ts",   32'(addr0), 32'd1);
    chk("a_id_cap",    id0,        GOOD_ID);
    step();
    chk("a_read_chk",  32'(read0), 32'd0);
    chk("a_addr_chk",  32'(addr0), 32'd0);
    chk("a_ts_cap",    ts0,        GOOD_TS);
    chk("a_done_early", 32'(done0), 32'd0);
    step();
    chk("a_done",      32'(done0),  32'd1);
    chk("a_mm",        32'(mm0),    32'd0);
    chk("a_valid",     32'(valid0), 32'd1);
    chk("a_err",       32'(err0),   32'd0);
    chk("a_busy_end",  32'(busy0),  32'd0);
    step();
    chk("a_done_pulse", 32'(done0), 32'd0);
    chk("a_id_hold",   id0,         GOOD_ID);

    // start held while busy is dropped, not queued
    start0 = 1'b1;
    step();
    step();
    step();
    start0 = 1'b0;
    step();
    chk("b_done", 32'(done0), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      seen = seen | busy0 | done0;
    end
    chk("b_no_requeue", 32'(seen), 32'd0);

    // waitrequest stall for 4 cycles in RD_ID
    wait0 = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      chk("c_stall_read",  32'(read0), 32'd1);
      chk("c_stall_addr",  32'(addr0), 32'd0);
      chk("c_stall_state", 32'(dbg0),  32'(ST_RD_ID));
      step();
      lat++;
    end
    wait0 = 1'b0;
    while (done0 !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
    chk("c_done_lat", 32'(lat), 32'd7);
    chk("c_mm",       32'(mm0), 32'd0);

    // wrong id word, then saturation of the error counter
    s0_id = 32'd3;
    run0(lat);
    chk("d_lat",  32'(lat),  32'd3);
    chk("d_mm",   32'(mm0),  32'd1);
    chk("d_err",  32'(err0), 32'd1);
    chk("d_id",   id0,       32'd3);
    for (int i = 1; i < 300; i++) begin
      run0(lat);
      if (i == 254) chk("d_err_255", 32'(err0), 32'd255);
    end
    chk("d_err_sat", 32'(err0), 32'd255);

    s0_id = GOOD_ID;
    s0_ts = 32'd0;
    run0(lat);
    chk("e_ts_mm",  32'(mm0),  32'd1);
    chk("e_ts_err", 32'(err0), 32'd255);
    s0_ts = GOOD_TS;
    run0(lat);
    chk("e_mm_clear", 32'(mm0),  32'd0);
    chk("e_err_keep", 32'(err0), 32'd255);

    rst0 = 1'b0;
    #1;
    chk("e_rst_err",   32'(err0),   32'd0);
    chk("e_rst_valid", 32'(valid0), 32'd0);
    chk("e_rst_id",    id0,         32'd0);
    rst0 = 1'b1;

    // READ_LATENCY=2 walk-through
    step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("f_state0", 32'(dbg1),  32'(ST_RD_ID));
    chk("f_read0",  32'(read1), 32'd1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("f_state", 32'(dbg1),  32'(exp_st1[i]));
      chk("f_read",  32'(read1), 32'(exp_rd1[i]));
      chk("f_addr",  32'(addr1), 32'(exp_ad1[i]));
      chk("f_done",  32'(done1), 32'(exp_dn1[i]));
      chk("f_id",    id1, (i >= 2) ? GOOD_ID : 32'd0);
      chk("f_ts",    ts1, (i >= 5) ? GOOD_TS : 32'd0);
    end
    chk("f_mm",    32'(mm1),    32'd0);
    chk("f_valid", 32'(valid1), 32'd1);

    // reset while waiting for the timestamp word
    step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("g_pre_state", 32'(dbg1), 32'(ST_WAIT_TS));
    rst1 = 1'b0;
    #1;
    chk("g_read",  32'(read1), 32'd0);
    chk("g_addr",  32'(addr1), 32'd0);
    chk("g_busy",  32'(busy1), 32'd0);
    chk("g_state", 32'(dbg1),  32'(ST_IDLE));
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | done1;
    end
    rst1 = 1'b1;
    step();
    seen = seen | done1;
    chk("g_no_done", 32'(seen), 32'd0);
    chk("g_err",     32'(err1), 32'd0);
    run1(lat);
    chk("g_lat",   32'(lat), 32'd7);
    chk("g_mm",    32'(mm1), 32'd0);
    chk("g_id",    id1,      GOOD_ID);
    chk("g_ts",    ts1,      GOOD_TS);

    // auto-recheck every RECHECK_CYCLES+4 edges (N idle + zero cycle + 3 check edges)
    rst2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      do begin
        step();
        cnt++;
        if (k == 1 && cnt == 12) begin
          chk("h_busy_state", 32'(dbg2), 32'(ST_RD_TS));
          start2 = 1'b1;
        end else if (k == 2 && cnt == 10) begin
          start2 = 1'b1;
        end else begin
          start2 = 1'b0;
        end
      end while (done2 !== 1'b1 && cnt < 100);
      chk("h_period", 32'(cnt),  32'd14);
      chk("h_mm",     32'(mm2),  32'd0);
      chk("h_busy",   32'(busy2), 32'd0);
    end
    chk("h_valid", 32'(valid2), 32'd1);
    chk("h_err",   32'(err2),   32'd0);
    chk("h_id",    id2,         GOOD_ID);
    chk("h_ts",    ts2,         GOOD_TS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
